mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master, single-port memory-bus arbiter and I/O decoder for the lab 7 bonus SoC. It shares the one synchronous-read RAM and the memory-mapped switch/LED registers between the CPU (master 0) and a debug loader (master 1) that writes and reads back program images. It sits between the masters and `MEM` inside `lab7bonus_top`, and produces the LED register that drives `LEDR[7:0]`.

## Interface
- `AW`, 9: address width in words.
- `DW`, 16: data width.
- `MEM_TOP`, 9'h0FF: highest RAM address. RAM occupies 0..MEM_TOP.
- `LED_ADDR`, 9'h100: write-only LED register.
- `SW_ADDR`, 9'h140: read-only switch port.
- `clk`  in  1: rising-edge clock (CLOCK_50).
- `reset`  in  1: asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1: the master requests an access. Held until accepted.
- `m0_write`, `m1_write`  in  1: 1 = write, 0 = read. Stable while req is high.
- `m0_addr`, `m1_addr`  in  AW: word address. Stable while req is high.
- `m0_wdata`, `m1_wdata`  in  DW: write data.
- `m0_gnt`, `m1_gnt`  out  1: combinational grant. At most one is high.
- `m0_rvalid`, `m1_rvalid`  out  1: registered. High one cycle after an accepted read.
- `rdata`  out  DW: registered read data. Valid when either rvalid is high.
- `mem_addr`  out  AW: RAM address. Combinational from the granted master.
- `mem_write`  out  1: RAM write enable.
- `mem_din`  out  DW: RAM write data.
- `mem_dout`  in  DW: RAM read data. Registered inside RAM, so it is valid the cycle after the address.
- `sw`  in  8: switch inputs.
- `led`  out  8: LED register.

## Operation
- **Acceptance.** A transaction is accepted on a rising edge where `mX_req & mX_gnt`. One transaction is accepted per cycle at most. Back-to-back acceptance is allowed every cycle.
- **Arbitration.** Round-robin using a 1-bit `last` register.
  - Only one master requests: it is granted.
  - Both request: the master that is not `last` is granted.
  - `last` updates to the accepted master on every acceptance.
  - No request: no grant, and `last` is unchanged.
- **Decode of the granted address.**
  - `addr <= MEM_TOP`: RAM access. `mem_write = write & gnt`.
  - `addr == LED_ADDR` with write: `led <= wdata[7:0]` at the accepting edge. A read of LED_ADDR returns {8'h00, led}.
  - `addr == SW_ADDR` with read: returns {8'h00, sw} sampled at the accepting edge. Writes to it are dropped.
  - Any other address: writes are dropped, reads return 16'h0000.
- **RAM protection.** `mem_write` is never high for an address outside RAM, nor when no master is granted.
- **Idle bus.** When no master is granted, `mem_addr` and `mem_din` follow master 0. This is don't-care for the RAM because `mem_write` = 0.
- **Read response.** A 1-cycle pipeline register holds `{owner, is_read, region}` for the accepted transaction.
  - Next cycle: `rdata` = `mem_dout` for RAM, otherwise the registered I/O or zero value.
  - `mX_rvalid` pulses for one cycle to the owner only.
- **Writes.** No rvalid is produced. The `gnt` edge is the completion.
- **Same-cycle ordering.** A read accepted the cycle after a write to the same address returns the new data, because the RAM write completes at the earlier edge.

## Timing
- **Reset values** (asynchronous, immediate):
  - `m0_rvalid = m1_rvalid = 0`
  - `rdata = 0`
  - `led = 0`
  - `last = 1`, so master 0 wins the first contention.
  - `mem_write = 0` while reset is high.
- **Read latency.** Accept at edge N gives rvalid/rdata valid in cycle N..N+1, sampled at edge N+1.
- **Write latency.** The write is visible at edge N.
- **Throughput.** One access per cycle in aggregate. Under continuous contention the grants alternate M0, M1, M0, …
- **Reset mid-operation.**
  - A pending rvalid is cancelled.
  - An unaccepted request is simply re-arbitrated after reset.
  - The loader must reissue any read whose rvalid was lost.
- **Dropping a request.** A master that drops req before grant has no effect. A master that changes addr/write while req is high without being granted is legal. Its request is treated as new.

## Test plan
- **Reset.** Assert reset mid-cycle with a read in flight: rvalid drops at once, `led` = 0. After release, with both masters requesting, M0 is granted first.
- **Loader write and readback.** M1 writes 16'hD004 to 0x000, then reads 0x000: `mem_write` pulses once, then `m1_rvalid` goes high 1 cycle after acceptance with `rdata` = 16'hD004, and `m0_rvalid` stays 0.
- **Contention.** Both masters request reads continuously for 6 cycles (M0 at 0x001, M1 at 0x002): the grant sequence is M0, M1, M0, M1, M0, M1, and each rvalid carries the correct owner's data.
- **I/O decode.** With SW = 10'b0000101001, M0 reads 0x140 and gets `rdata` = 16'h0029. M0 then writes 16'h1234 to 0x100: `led` = 8'h34 and `mem_write` stays 0.
- **Unmapped and protection.** A write to 0x1F0 is dropped: RAM is unchanged and `led` is unchanged. A read of 0x1F0 returns 16'h0000 with rvalid.
- **Write-then-read.** M0 writes 16'hABCD to 0x014 at edge N and M1 reads 0x014 at edge N+1: M1 receives 16'hABCD.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter: two-master round-robin arbiter for one sync-read RAM plus
// a write-only LED register and a read-only switch port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int            AW       = 9,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] MEM_TOP  = 9'h0FF,
  parameter logic [AW-1:0] LED_ADDR = 9'h100,
  parameter logic [AW-1:0] SW_ADDR  = 9'h140
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic [7:0]    sw,
  output logic [7:0]    led
);

  logic          last_q, last_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic          ram_q, ram_d;
  logic [DW-1:0] io_q, io_d;
  logic [7:0]    led_q, led_d;

  logic          sel;
  logic          accept;
  logic          wr;
  logic          is_ram;
  logic          is_led;
  logic          is_sw;

  // last_q == 1 means master 1 was served most recently, so master 0 wins a tie.
  always_comb begin
    m0_gnt = ~reset & m0_req & (~m1_req | last_q);
    m1_gnt = ~reset & m1_req & (~m0_req | ~last_q);
    sel    = m1_gnt;
    accept = m0_gnt | m1_gnt;

    mem_addr = sel ? m1_addr  : m0_addr;
    mem_din  = sel ? m1_wdata : m0_wdata;
    wr       = sel ? m1_write : m0_write;

    is_ram    = (mem_addr <= MEM_TOP);
    is_led    = (mem_addr == LED_ADDR);
    is_sw     = (mem_addr == SW_ADDR);
    mem_write = accept & wr & is_ram;
  end

  always_comb begin
    last_d      = last_q;
    led_d       = led_q;
    ram_d       = ram_q;
    io_d        = io_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;

    if (accept) begin
      last_d = sel;
      if (wr) begin
        if (is_led) begin
          led_d = mem_din[7:0];
        end
      end else begin
        m0_rvalid_d = ~sel;
        m1_rvalid_d = sel;
        ram_d       = is_ram;
        if (is_led) begin
          io_d = {{(DW-8){1'b0}}, led_q};
        end else if (is_sw) begin
          io_d = {{(DW-8){1'b0}}, sw};
        end else begin
          io_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q      <= 1'b1;
      led_q       <= 8'h00;
      ram_q       <= 1'b0;
      io_q        <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      led_q       <= led_d;
      ram_q       <= ram_d;
      io_q        <= io_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  // RAM data arrives registered inside the RAM, so it is steered straight through.
  assign rdata     = ram_q ? mem_dout : io_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign led       = led_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter: transaction-level model check plus directed scenarios.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_write = 1'b0;
  logic [8:0]  m0_addr = '0;
  logic [15:0] m0_wdata = '0;
  logic        m1_req = 1'b0, m1_write = 1'b0;
  logic [8:0]  m1_addr = '0;
  logic [15:0] m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] rdata;
  logic [8:0]  mem_addr;
  logic        mem_write;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;
  logic [7:0]  sw = 8'h00;
  logic [7:0]  led;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_write(mem_write), .mem_din(mem_din),
    .mem_dout(mem_dout), .sw(sw), .led(led)
  );

  always #5 clk = ~clk;

  // RAM with registered read; contents are never reset
  logic [15:0] ram [0:511];
  bit          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 512; i++) ram[i] <= 16'h5A5A ^ 16'(i);
      ram_loaded <= 1'b1;
    end else begin
      if (mem_write) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference model
  logic [15:0] shadow [0:255];
  bit          sh_loaded = 1'b0;
  bit          mlast = 1'b1;
  bit          mv0 = 1'b0, mv1 = 1'b0;
  logic [15:0] mexp = '0;
  logic [7:0]  mled = '0;
  bit          g0, g1;
  logic [8:0]  ma;
  logic [15:0] md;
  bit          mw;

  always @(posedge clk or posedge reset) begin
    if (!sh_loaded) begin
      for (int i = 0; i < 256; i++) shadow[i] = 16'h5A5A ^ 16'(i);
      sh_loaded = 1'b1;
    end
    if (reset) begin
      mv0 = 1'b0; mv1 = 1'b0; mlast = 1'b1; mled = 8'h00;
    end else begin
      g0 = m0_req && (!m1_req || mlast);
      g1 = m1_req && (!m0_req || !mlast);
      mv0 = 1'b0; mv1 = 1'b0;
      if (g0 || g1) begin
        ma = g1 ? m1_addr  : m0_addr;
        md = g1 ? m1_wdata : m0_wdata;
        mw = g1 ? m1_write : m0_write;
        if (mw) begin
          if (ma < 9'h100)       shadow[ma[7:0]] = md;
          else if (ma == 9'h100) mled = md[7:0];
        end else begin
          if (ma < 9'h100)       mexp = shadow[ma[7:0]];
          else if (ma == 9'h100) mexp = {8'h00, mled};
          else if (ma == 9'h140) mexp = {8'h00, sw};
          else                   mexp = 16'h0000;
          mv0 = g0; mv1 = g1;
        end
        mlast = g1;
      end
    end
  end

  // Compare process: every negative edge
  always @(negedge clk) begin
    bit e0, e1;
    bit [8:0] ea;
    bit [15:0] ed;
    bit ew;
    if (reset) begin
      chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
      chk("rst_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
      chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
      chk("rst_led", {24'b0, led}, 32'd0);
    end else begin
      e0 = m0_req && (!m1_req || mlast);
      e1 = m1_req && (!m0_req || !mlast);
      ea = e1 ? m1_addr  : m0_addr;
      ed = e1 ? m1_wdata : m0_wdata;
      ew = e1 ? m1_write : m0_write;
      chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, e0});
      chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, e1});
      chk("mem_addr", {23'b0, mem_addr}, {23'b0, ea});
      chk("mem_din", {16'b0, mem_din}, {16'b0, ed});
      chk("mem_write", {31'b0, mem_write}, {31'b0, ((e0 || e1) && ew && ea < 9'h100)});
      chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, mv0});
      chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, mv1});
      if (mv0 || mv1) chk("rdata", {16'b0, rdata}, {16'b0, mexp});
      chk("led", {24'b0, led}, {24'b0, mled});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] gseq [0:5];
  logic [1:0] gexp [0:5];

  initial begin
    gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01;
    gexp[3] = 2'b10; gexp[4] = 2'b01; gexp[5] = 2'b10;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_rdata", {16'b0, rdata}, 32'h0);
    chk("reset_led", {24'b0, led}, 32'h0);
    reset = 1'b0;
    cyc();

    // Set LED so the reset check below means something
    m0_req = 1; m0_write = 1; m0_addr = 9'h100; m0_wdata = 16'h005A;
    cyc();
    m0_req = 0; m0_write = 0;
    chk("led_pre", {24'b0, led}, 32'h5A);

    // Read in flight, then reset mid-cycle
    m0_req = 1; m0_addr = 9'h003;
    cyc();
    m0_req = 0;
    #1;
    chk("inflight_rvalid", {31'b0, m0_rvalid}, 32'd1);
    reset = 1'b1;
    m0_req = 1; m0_write = 0; m0_addr = 9'h001;
    m1_req = 1; m1_write = 0; m1_addr = 9'h002;
    #1;
    chk("midrst_rvalid", {31'b0, m0_rvalid}, 32'd0);
    chk("midrst_led", {24'b0, led}, 32'd0);
    #4 reset = 1'b0;
    #1;

    // Contention: grants alternate starting with M0
    for (int i = 0; i < 6; i++) begin
      gseq[i] = {m1_gnt, m0_gnt};
      @(posedge clk);
      #1;
    end
    m0_req = 0; m1_req = 0;
    for (int i = 0; i < 6; i++) chk("grant_seq", {30'b0, gseq[i]}, {30'b0, gexp[i]});
    chk("cont_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
    chk("cont_rdata", {16'b0, rdata}, 32'h5A58);

    // Loader write then readback
    m1_req = 1; m1_write = 1; m1_addr = 9'h000; m1_wdata = 16'hD004;
    #1;
    chk("ld_mem_write", {31'b0, mem_write}, 32'd1);
    cyc();
    m1_req = 0; m1_write = 0;
    #1;
    chk("ld_mem_write_off", {31'b0, mem_write}, 32'd0);
    m1_req = 1; m1_addr = 9'h000;
    cyc();
    m1_req = 0;
    chk("ld_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
    chk("ld_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    chk("ld_rdata", {16'b0, rdata}, 32'hD004);

    // I/O decode
    sw = 8'h29;
    m0_req = 1; m0_write = 0; m0_addr = 9'h140;
    cyc();
    m0_req = 0;
    chk("sw_rvalid", {31'b0, m0_rvalid}, 32'd1);
    chk("sw_rdata", {16'b0, rdata}, 32'h0029);
    m0_req = 1; m0_write = 1; m0_addr = 9'h100; m0_wdata = 16'h1234;
    #1;
    chk("led_mem_write", {31'b0, mem_write}, 32'd0);
    cyc();
    m0_req = 0; m0_write = 0;
    chk("led_val", {24'b0, led}, 32'h34);

    // Unmapped write dropped, read returns zero
    m0_req = 1; m0_write = 1; m0_addr = 9'h1F0; m0_wdata = 16'hFFFF;
    #1;
    chk("unmap_mem_write", {31'b0, mem_write}, 32'd0);
    cyc();
    m0_write = 0;
    chk("unmap_led", {24'b0, led}, 32'h34);
    cyc();
    m0_req = 0;
    chk("unmap_rvalid", {31'b0, m0_rvalid}, 32'd1);
    chk("unmap_rdata", {16'b0, rdata}, 32'h0000);
    m0_req = 1; m0_addr = 9'h0F0;
    cyc();
    m0_req = 0;
    chk("unmap_ram_intact", {16'b0, rdata}, {16'b0, 16'h5A5A ^ 16'h00F0});

    // Write at edge N, read by the other master at edge N+1
    m0_req = 1; m0_write = 1; m0_addr = 9'h014; m0_wdata = 16'hABCD;
    cyc();
    m0_req = 0; m0_write = 0;
    m1_req = 1; m1_write = 0; m1_addr = 9'h014;
    cyc();
    m1_req = 0;
    chk("wtr_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
    chk("wtr_rdata", {16'b0, rdata}, 32'hABCD);

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
